onehot_encoder_stream: RTL and testbench



---
 rtl/onehot_encoder_stream_if.sv | 24 ++
 rtl/onehot_encoder_stream.sv | 86 ++++++++
 tb/tb_onehot_encoder_stream.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/onehot_encoder_stream_if.sv
// Stream bundle for onehot_encoder_stream: n-bit vector in, m-bit index beats out.
// slave = encoder side, master = environment side.
interface onehot_encoder_stream_if #(
    parameter int m = 3,
    parameter int n = 2**m
);
    logic [n-1:0] recv_msg;
    logic         recv_val;
    logic         recv_rdy;
    logic [m-1:0] send_msg;
    logic         send_last;
    logic         send_val;
    logic         send_rdy;

    modport slave (
        input  recv_msg, recv_val, send_rdy,
        output recv_rdy, send_msg, send_last, send_val
    );

    modport master (
        output recv_msg, recv_val, send_rdy,
        input  recv_rdy, send_msg, send_last, send_val
    );
endinterface

// File: rtl/onehot_encoder_stream.sv
// Streams the index of every set bit of an accepted vector, one index per beat.
// Default order is MSB-first; define ENCODER_LSB_FIRST_EN for LSB-first.
module onehot_encoder_stream #(
    parameter int m = 3,
    parameter int n = 2**m
) (
    input  logic                   clk,
    input  logic                   reset,
    onehot_encoder_stream_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t       state_reg, state_next;
    logic [n-1:0] pending_reg, pending_next;
    logic         armed_reg;
    logic [m-1:0] idx;
    logic         single;
    logic         recv_fire;
    logic         send_fire;

    // armed_reg keeps recv_rdy low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
            armed_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            armed_reg   <= 1'b1;
        end
    end

    // Later assignments win, so the scan direction selects the emitted bit.
    always_comb begin
        idx = '0;
`ifdef ENCODER_LSB_FIRST_EN
        for (int i = n - 1; i >= 0; i--) begin
            if (pending_reg[i]) idx = m'(i);
        end
`else
        for (int i = 0; i < n; i++) begin
            if (pending_reg[i]) idx = m'(i);
        end
`endif
    end

    assign single    = (pending_reg & (pending_reg - n'(1))) == '0;
    assign recv_fire = bus.recv_val & bus.recv_rdy;
    assign send_fire = bus.send_val & bus.send_rdy;

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        case (state_reg)
            IDLE: begin
                // An all-zero vector is consumed without producing beats.
                if (recv_fire && bus.recv_msg != '0) begin
                    pending_next = bus.recv_msg;
                    state_next   = BUSY;
                end
            end
            BUSY: begin
                if (send_fire) begin
                    pending_next = pending_reg & ~(n'(1) << idx);
                    if (single) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.recv_rdy  = 1'b0;
        bus.send_val  = 1'b0;
        bus.send_msg  = '0;
        bus.send_last = 1'b0;
        if (state_reg == IDLE) begin
            bus.recv_rdy = armed_reg;
        end else begin
            bus.send_val  = 1'b1;
            bus.send_msg  = idx;
            bus.send_last = single;
        end
    end
endmodule

// File: tb/tb_onehot_encoder_stream.sv
// Bench for onehot_encoder_stream: queue-of-indices reference model, directed cases, random traffic.
// Honours ENCODER_LSB_FIRST_EN for the emission order.
module tb_onehot_encoder_stream;
    localparam int M = 3;
    localparam int N = 1 << M;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    onehot_encoder_stream_if #(.m(M), .n(N)) bus ();
    onehot_encoder_stream #(.m(M), .n(N)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    // Reference: outstanding indices in emission order; armed once out of reset for an edge.
    int   q[$];
    bit   armed;
    int   checks;
    int   failures;
    int   log_msg[$];
    bit   log_last[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_vec(input logic [N-1:0] v);
`ifdef ENCODER_LSB_FIRST_EN
        for (int i = 0; i < N; i++) if (v[i]) q.push_back(i);
`else
        for (int i = N - 1; i >= 0; i--) if (v[i]) q.push_back(i);
`endif
    endtask

    // One cycle: compare at negedge, advance the model at posedge, release #1 later.
    task automatic step();
        bit exp_rdy, exp_val, exp_last;
        int exp_msg;
        @(negedge clk);
        exp_rdy  = armed && (q.size() == 0);
        exp_val  = q.size() != 0;
        exp_msg  = exp_val ? q[0] : 0;
        exp_last = q.size() == 1;
        chk("recv_rdy", int'(bus.recv_rdy), int'(exp_rdy));
        chk("send_val", int'(bus.send_val), int'(exp_val));
        chk("send_msg", int'(bus.send_msg), exp_msg);
        chk("send_last", int'(bus.send_last), int'(exp_last));
        if (bus.send_val && bus.send_rdy) begin
            log_msg.push_back(int'(bus.send_msg));
            log_last.push_back(bus.send_last);
        end
        @(posedge clk);
        if (exp_val && bus.send_rdy) void'(q.pop_front());
        if (exp_rdy && bus.recv_val) begin
            if (bus.recv_msg != '0) begin
                push_vec(bus.recv_msg);
                $display("vec %b accepted beats=%0d", bus.recv_msg, q.size());
            end else begin
                $display("vec %b accepted and dropped", bus.recv_msg);
            end
        end
        armed = 1'b1;
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_recv_rdy"}, int'(bus.recv_rdy), 0);
        chk({tag, "_send_val"}, int'(bus.send_val), 0);
        chk({tag, "_send_msg"}, int'(bus.send_msg), 0);
        chk({tag, "_send_last"}, int'(bus.send_last), 0);
    endtask

    // Called at posedge+1; reset takes effect without waiting for a clock edge.
    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        bus.recv_val = 1'b1;
        #1;
        q.delete();
        armed = 1'b0;
        check_zero_outputs("rst_async");
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check_zero_outputs("rst_hold");
        end
        @(posedge clk);
        #1;
        bus.recv_val = 1'b0;
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60 && !(armed && q.size() == 0); k++) step();
        chk("idle_timeout", int'(armed && q.size() == 0), 1);
    endtask

    task automatic check_log(input string name, input int exp_l[$], input bit final_last);
        chk({name, "_beats"}, log_msg.size(), exp_l.size());
        for (int i = 0; i < exp_l.size() && i < log_msg.size(); i++) begin
            chk({name, "_msg"}, log_msg[i], exp_l[i]);
            chk({name, "_last"}, int'(log_last[i]), int'(final_last && i == exp_l.size() - 1));
        end
    endtask

    task automatic send_one(input logic [N-1:0] v);
        bus.recv_val = 1'b1;
        bus.recv_msg = v;
        step();
        bus.recv_val = 1'b0;
    endtask

    initial begin
        int exp_l[$];
        int stall_msg;
        checks   = 0;
        failures = 0;
        armed    = 1'b0;
        bus.recv_val = 1'b1;
        bus.recv_msg = 8'hFF;
        bus.send_rdy = 1'b1;

        // Power-up reset held with recv_val=1.
        repeat (3) begin
            @(negedge clk);
            check_zero_outputs("rst_init");
        end
        @(posedge clk);
        #1;
        bus.recv_val = 1'b0;
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("rdy_after_release", int'(bus.recv_rdy), 1);
        @(posedge clk);
        #1;

        // Single bit.
        log_msg.delete(); log_last.delete();
        send_one(8'b0010_0000);
        @(negedge clk);
        chk("single_first_val", int'(bus.send_val), 1);
        @(posedge clk);
        #1;
        // The negedge check above was outside step(), so replay the pop by hand.
        void'(q.pop_front());
        log_msg.push_back(5); log_last.push_back(1'b1);
        @(negedge clk);
        chk("single_rdy_after", int'(bus.recv_rdy), 1);
        @(posedge clk);
        #1;
        exp_l = '{5};
        check_log("single", exp_l, 1'b1);

        // Multi bit.
        wait_idle();
        log_msg.delete(); log_last.delete();
        send_one(8'b1000_1010);
        wait_idle();
        exp_l = '{7, 3, 1};
`ifdef ENCODER_LSB_FIRST_EN
        exp_l.reverse();
`endif
        check_log("multi", exp_l, 1'b1);

        // Backpressure.
        log_msg.delete(); log_last.delete();
        bus.send_rdy = 1'b0;
        send_one(8'b0000_0101);
`ifdef ENCODER_LSB_FIRST_EN
        stall_msg = 0;
`else
        stall_msg = 2;
`endif
        for (int k = 0; k < 4; k++) begin
            step();
            chk("stall_msg", int'(bus.send_msg), stall_msg);
            chk("stall_last", int'(bus.send_last), 0);
            chk("stall_rdy", int'(bus.recv_rdy), 0);
        end
        bus.send_rdy = 1'b1;
        wait_idle();
        exp_l = '{2, 0};
`ifdef ENCODER_LSB_FIRST_EN
        exp_l.reverse();
`endif
        check_log("bp", exp_l, 1'b1);

        // Zero vector then an immediate single-bit vector.
        log_msg.delete(); log_last.delete();
        bus.recv_val = 1'b1;
        bus.recv_msg = '0;
        step();
        chk("zero_no_val", int'(bus.send_val), 0);
        bus.recv_msg = 8'b0000_0001;
        step();
        bus.recv_val = 1'b0;
        wait_idle();
        exp_l = '{0};
        check_log("zero_then_one", exp_l, 1'b1);

        // Reset mid-stream after three beats.
        log_msg.delete(); log_last.delete();
        send_one(8'hFF);
        repeat (3) step();
        exp_l = '{7, 6, 5};
`ifdef ENCODER_LSB_FIRST_EN
        exp_l = '{0, 1, 2};
`endif
        check_log("pre_reset", exp_l, 1'b0);
        do_reset(2);
        step();
        log_msg.delete(); log_last.delete();
        wait_idle();
        send_one(8'b1000_0000);
        wait_idle();
        exp_l = '{7};
        check_log("post_reset", exp_l, 1'b1);

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            bus.recv_val = ($urandom_range(0, 3) != 0);
            bus.recv_msg = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            bus.send_rdy = ($urandom_range(0, 9) < 7);
            if (c == 400) do_reset(1);
            step();
        end
        bus.recv_val = 1'b0;
        bus.send_rdy = 1'b1;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
